// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int PKG_XLEN   = 32;
  localparam int INST_BYTES = 4;

  localparam logic [PKG_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // RUN: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fsm_t;

  // One buffered instruction together with the address it was fetched from
  typedef struct packed {
    logic [PKG_XLEN-1:0] pc;
    logic [PKG_XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so an address always names a whole instruction word
  function automatic logic [PKG_XLEN-1:0] word_align(input logic [PKG_XLEN-1:0] addr);
    return addr & ~(PKG_XLEN'(INST_BYTES - 1));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular buffer of fetch_entry_t between imem responses and the decoder.
// Latency: a push is visible at the head on the next cycle; the head is read combinationally.
// Backpressure: pushes beyond DEPTH are ignored (the fetch side never issues them); flush wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  // A flush cancels any push or pop presented in the same cycle.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != FULL) || do_pop);

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues one-at-a-time imem word reads, buffers results for the decoder.
// Latency: grant in G, response in R -> inst_valid in R+1 (in R when FETCH_BYPASS_EN and FIFO empty).
// Backpressure: inst_ready low fills the FIFO; imem_req drops while full or while a read is outstanding.
// Build option FETCH_BYPASS_EN: forward a kept response straight to the decoder when the FIFO is empty.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int              CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);

  fsm_t            fsm;
  fsm_t            fsm_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic grant;
  logic resp_keep;
  logic fifo_empty;
  logic bypass;
  logic push;
  logic pop_fifo;

  // Request depends on registered state only, so the memory never sees a combinational loop.
  assign imem_req   = (fsm == RUN) && (count < FULL_COUNT) && !rst;
  assign imem_addr  = fetch_pc;
  assign grant      = imem_req && imem_gnt;
  assign fifo_empty = (count == '0);

  // A response is kept only when it belongs to the current stream and no redirect is arriving.
  assign resp_keep  = (fsm == WAIT) && imem_rvalid && !jump_flag;

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && fifo_empty && !rst;
`else
  assign bypass = 1'b0;
`endif

  // Decoder-facing head: buffered entry first, otherwise a same-cycle response when bypassing.
  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    if (!fifo_empty) begin
      inst_valid = 1'b1;
      inst       = head.inst;
      inst_pc    = head.pc;
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = req_pc;
    end
  end

  // A bypassed word already consumed by the decoder must not also be buffered.
  always_comb begin
    push_entry      = '0;
    push_entry.pc   = req_pc;
    push_entry.inst = imem_rdata;
    push            = resp_keep && !(bypass && inst_ready);
    pop_fifo        = inst_valid && inst_ready && !fifo_empty;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop_fifo),
    .flush      (jump_flag),
    .count      (count),
    .head       (head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) fsm <= RUN;
    else     fsm <= fsm_nxt;
  end

  // Next state: a redirect turns any outstanding or just-granted read into one to discard.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      RUN: begin
        if (grant) fsm_nxt = jump_flag ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rvalid)    fsm_nxt = RUN;
        else if (jump_flag) fsm_nxt = DROP;
      end
      DROP: begin
        if (imem_rvalid) fsm_nxt = RUN;
      end
      default: fsm_nxt = RUN;
    endcase
  end

  // Fetch PC: redirect wins over the sequential advance of a granted request.
  always_ff @(posedge clk) begin
    if (rst)            fetch_pc <= word_align(RESET_PC);
    else if (jump_flag) fetch_pc <= word_align(jump_target);
    else if (grant)     fetch_pc <= fetch_pc + PC_STEP;
  end

  // Remember the address of the outstanding read so its data can be tagged on return.
  always_ff @(posedge clk) begin
    if (rst)        req_pc <= '0;
    else if (grant) req_pc <= fetch_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench with a behavioural memory and an in-order stream model.
// Latency: memory answers 1..4 cycles after a grant; model expects consecutive words from the last redirect.
// Backpressure: grant and decoder ready are fixed or random per scenario.
module tb_fetch_unit;

  localparam logic [31:0] XORK = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .jump_flag   (jump_flag),
    .jump_target (jump_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  int checks = 0;
  int errors = 0;

  // Memory model state and scenario knobs
  bit          mem_pend;
  logic [31:0] mem_addr;
  int          mem_lat;
  int          lat_fix;
  bit          lat_rand;
  bit          gnt_rand;
  bit          rdy_rand;
  bit          rdy_val;

  // Observations of the most recent cycle
  bit          o_req, o_gnt, o_valid, o_pop, o_rsp;
  logic [31:0] o_addr, o_pc, o_inst;

  // Reference: next address the decoder must receive
  logic [31:0] exp_pc;

  // One clock: drive inputs at negedge, sample settled outputs, then advance the memory at posedge.
  task automatic cycle(input bit r, input bit j, input logic [31:0] tgt);
    @(negedge clk);
    rst         = r;
    jump_flag   = j;
    jump_target = tgt;
    if (mem_pend && mem_lat == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_addr ^ XORK;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt   = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    inst_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    #1;
    o_req   = imem_req;
    o_gnt   = imem_req && imem_gnt;
    o_addr  = imem_addr;
    o_valid = inst_valid;
    o_pop   = inst_valid && inst_ready;
    o_pc    = inst_pc;
    o_inst  = inst;
    o_rsp   = imem_rvalid;
    @(posedge clk);
    if (r) begin
      mem_pend = 1'b0;
    end else begin
      if (o_rsp) mem_pend = 1'b0;
      else if (mem_pend && mem_lat > 0) mem_lat--;
      if (o_gnt) begin
        mem_pend = 1'b1;
        mem_addr = o_addr;
        mem_lat  = lat_rand ? int'($urandom_range(0, 3)) : lat_fix - 1;
      end
    end
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    exp_pc = 32'h0;
  endtask

  task automatic test_reset();
    gnt_rand = 1; rdy_rand = 1; lat_rand = 1;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), $urandom);
    exp_pc = 32'h0;
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_req); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", o_inst); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", o_pc); end
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", o_addr); end
  endtask

  task automatic test_fetch_sequence();
    int first_g = -1, first_p = -1, last_p = -1, npop = 0, spacing_bad = 0;
    gnt_rand = 0; rdy_rand = 0; rdy_val = 1; lat_rand = 0; lat_fix = 1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (i == 0) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h0) begin
          errors++; $display("FAIL first_req: got req %b addr %h want req 1 addr 0", o_req, o_addr);
        end
      end
      if (o_gnt && first_g < 0) first_g = i;
      if (o_pop) begin
        checks++;
        if (o_pc !== exp_pc || o_inst !== (exp_pc ^ XORK)) begin
          errors++; $display("FAIL seq_stream: got pc %h inst %h want pc %h inst %h", o_pc, o_inst, exp_pc, exp_pc ^ XORK);
        end
        exp_pc += 32'd4;
        if (first_p < 0) first_p = i;
        else if (i - last_p != 2) spacing_bad++;
        last_p = i;
        npop++;
      end
    end
    checks++;
    if (first_p - first_g != EXP_LAT) begin
      errors++; $display("FAIL first_latency: got %0d cycles want %0d", first_p - first_g, EXP_LAT);
    end
    checks++;
    if (spacing_bad != 0 || npop < 5) begin
      errors++; $display("FAIL throughput: got %0d pops %0d bad gaps want >=5 pops 0 bad gaps", npop, spacing_bad);
    end
  endtask

  task automatic test_backpressure();
    int ng = 0, npop = 0, early_pop = 0;
    gnt_rand = 0; rdy_rand = 0; rdy_val = 0; lat_rand = 0; lat_fix = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      ng += int'(o_gnt);
      early_pop += int'(o_pop);
    end
    checks++; if (ng != 2) begin errors++; $display("FAIL stall_grants: got %0d want 2", ng); end
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL stall_req: got %b want 0", o_req); end
    checks++; if (o_valid !== 1'b1 || early_pop != 0) begin
      errors++; $display("FAIL stall_valid: got valid %b pops %0d want valid 1 pops 0", o_valid, early_pop);
    end
    rdy_val = 1;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (o_pop) begin
        checks++;
        if (o_pc !== exp_pc || o_inst !== (exp_pc ^ XORK)) begin
          errors++; $display("FAIL drain_stream: got pc %h inst %h want pc %h inst %h", o_pc, o_inst, exp_pc, exp_pc ^ XORK);
        end
        exp_pc += 32'd4;
        npop++;
      end
    end
    checks++; if (npop < 4) begin errors++; $display("FAIL drain_count: got %0d want >=4", npop); end
  endtask

  task automatic test_jump_in_wait();
    int first_pc_seen = 0, first_g_seen = 0;
    gnt_rand = 0; rdy_rand = 0; rdy_val = 1; lat_rand = 0; lat_fix = 3;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    checks++; if (o_gnt !== 1'b1) begin errors++; $display("FAIL jw_grant: got %b want 1", o_gnt); end
    cycle(1'b0, 1'b1, 32'h0000_0100);
    exp_pc = 32'h0000_0100;
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (o_addr !== 32'h100 || o_valid !== 1'b0 || o_req !== 1'b0) begin
      errors++; $display("FAIL jw_after: got addr %h valid %b req %b want 100 0 0", o_addr, o_valid, o_req);
    end
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (o_gnt && !first_g_seen) begin
        first_g_seen = 1;
        checks++;
        if (o_addr !== 32'h100) begin errors++; $display("FAIL jw_grant_addr: got %h want 100", o_addr); end
      end
      if (o_pop) begin
        if (!first_pc_seen) begin
          first_pc_seen = 1;
          checks++;
          if (o_pc !== 32'h100) begin errors++; $display("FAIL jw_first_pc: got %h want 100", o_pc); end
        end
        checks++;
        if (o_pc !== exp_pc || o_inst !== (exp_pc ^ XORK)) begin
          errors++; $display("FAIL jw_stream: got pc %h inst %h want pc %h inst %h", o_pc, o_inst, exp_pc, exp_pc ^ XORK);
        end
        exp_pc += 32'd4;
      end
    end
    checks++;
    if (!first_pc_seen || !first_g_seen) begin
      errors++; $display("FAIL jw_progress: got pop %0d grant %0d want 1 1", first_pc_seen, first_g_seen);
    end
  endtask

  task automatic test_jump_resp_pop();
    int npop = 0;
    gnt_rand = 0; rdy_rand = 0; rdy_val = 0; lat_rand = 0; lat_fix = 1;
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0);
    rdy_val = 1;
    cycle(1'b0, 1'b1, 32'h0000_0203);
    checks++;
    if (o_pop !== 1'b1 || o_rsp !== 1'b1 || o_pc !== exp_pc) begin
      errors++; $display("FAIL jrp_setup: got pop %b rsp %b pc %h want 1 1 %h", o_pop, o_rsp, o_pc, exp_pc);
    end
    exp_pc = 32'h0000_0200;
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (o_valid !== 1'b0 || o_addr !== 32'h200 || o_req !== 1'b1) begin
      errors++; $display("FAIL jrp_after: got valid %b addr %h req %b want 0 200 1", o_valid, o_addr, o_req);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (o_pop) begin
        checks++;
        if (o_pc !== exp_pc || o_inst !== (exp_pc ^ XORK)) begin
          errors++; $display("FAIL jrp_stream: got pc %h inst %h want pc %h inst %h", o_pc, o_inst, exp_pc, exp_pc ^ XORK);
        end
        exp_pc += 32'd4;
        npop++;
      end
    end
    checks++; if (npop < 3) begin errors++; $display("FAIL jrp_count: got %0d want >=3", npop); end
  endtask

  task automatic test_reset_in_drop();
    int first_seen = 0;
    gnt_rand = 0; rdy_rand = 0; rdy_val = 1; lat_rand = 0; lat_fix = 3;
    do_reset();
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0300);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    exp_pc = 32'h0;
    checks++;
    if (o_req !== 1'b0 || o_valid !== 1'b0 || o_pc !== 32'h0 || o_inst !== 32'h0 || o_addr !== 32'h0) begin
      errors++; $display("FAIL rd_reset: got req %b valid %b pc %h inst %h addr %h want all 0", o_req, o_valid, o_pc, o_inst, o_addr);
    end
    cycle(1'b0, 1'b0, 32'h0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h0) begin
      errors++; $display("FAIL rd_refetch: got req %b addr %h want 1 0", o_req, o_addr);
    end
    gnt_rand = 1; rdy_rand = 1; lat_rand = 1;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      if (o_pop) begin
        if (!first_seen) begin
          first_seen = 1;
          checks++;
          if (o_pc !== 32'h0) begin errors++; $display("FAIL rd_first_pc: got %h want 0", o_pc); end
        end
        checks++;
        if (o_pc !== exp_pc || o_inst !== (exp_pc ^ XORK)) begin
          errors++; $display("FAIL rd_stream: got pc %h inst %h want pc %h inst %h", o_pc, o_inst, exp_pc, exp_pc ^ XORK);
        end
        exp_pc += 32'd4;
      end
    end
  endtask

  task automatic test_back_to_back();
    int npop = 0, bad_align = 0;
    bit j;
    logic [31:0] tgt;
    gnt_rand = 1; rdy_rand = 1; lat_rand = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      j   = ($urandom_range(0, 99) < 4);
      tgt = $urandom;
      cycle(1'b0, j, tgt);
      if (o_req && o_addr[1:0] != 2'b00) bad_align++;
      if (o_pop) begin
        checks++;
        if (o_pc !== exp_pc || o_inst !== (exp_pc ^ XORK)) begin
          errors++; $display("FAIL rand_stream: cycle %0d got pc %h inst %h want pc %h inst %h", i, o_pc, o_inst, exp_pc, exp_pc ^ XORK);
        end
        exp_pc += 32'd4;
        npop++;
      end
      if (j) exp_pc = tgt & 32'hFFFF_FFFC;
    end
    checks++; if (bad_align != 0) begin errors++; $display("FAIL rand_align: got %0d misaligned want 0", bad_align); end
    checks++; if (npop < 20) begin errors++; $display("FAIL rand_progress: got %0d pops want >=20", npop); end
  endtask

  initial begin
    rst = 1'b1; jump_flag = 1'b0; jump_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    mem_pend = 1'b0; mem_addr = '0; mem_lat = 0;
    lat_fix = 1; lat_rand = 0; gnt_rand = 0; rdy_rand = 0; rdy_val = 1;
    exp_pc = '0;
    test_reset();
    test_fetch_sequence();
    test_backpressure();
    test_jump_in_wait();
    test_jump_resp_pop();
    test_reset_in_drop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule
